// File: rtl/sdpram_pkg.sv
// Shared constants and helpers for the sdpram_dist_reg family.
package sdpram_pkg;

  localparam string WM_READ_FIRST  = "READ_FIRST";
  localparam string WM_WRITE_FIRST = "WRITE_FIRST";

  localparam int unsigned MAX_WIDTH = 64;

  // Output-register load value: all-ones for SET, all-zeros otherwise.
  function automatic logic [MAX_WIDTH-1:0] rst_word(input bit set, input int unsigned width);
    logic [MAX_WIDTH-1:0] w;
    w = set ? ({MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width)) : '0;
    return w;
  endfunction

  function automatic bit aw_ok(input int unsigned aw);
    return (aw >= 1) && (aw <= 8);
  endfunction

  function automatic bit width_ok(input int unsigned width);
    return (width >= 1) && (width <= MAX_WIDTH);
  endfunction

  function automatic bit stages_ok(input int unsigned stages);
    return (stages == 1) || (stages == 2);
  endfunction

endpackage

// File: rtl/rd_pipe_stage.sv
// One registered read stage: data plus valid, clock enable, synchronous set/reset.
module rd_pipe_stage
  import sdpram_pkg::*;
#(
  parameter int unsigned     WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic             CE,
  input  logic             LD,
  input  logic             VIN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);

  logic [WIDTH-1:0] q_q;
  logic             qv_q;

  // LSR wins over CE; data only moves when LD is set so Q holds across bubbles.
  always_ff @(posedge CLK) begin
    if (LSR) begin
      q_q  <= RST_VAL;
      qv_q <= 1'b0;
    end else if (CE) begin
      qv_q <= VIN;
      if (LD) begin
        q_q <= D;
      end
    end
  end

  assign Q  = q_q;
  assign QV = qv_q;

endmodule

// File: rtl/sdpram_dist_reg.sv
// Simple-dual-port distributed RAM with async read port F and a registered,
// clock-enabled read pipeline Q/QV.
module sdpram_dist_reg
  import sdpram_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned AW         = 4,
  parameter int unsigned REG_STAGES = 1,
  parameter string       WRITE_MODE = "READ_FIRST",
  parameter string       REGSET     = "RESET"
) (
  input  logic             CLK,
  input  logic             LSR,
  input  logic             WRE,
  input  logic [AW-1:0]    WAD,
  input  logic [WIDTH-1:0] WD,
  input  logic             RE,
  input  logic [AW-1:0]    RAD,
  input  logic             CE,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] Q,
  output logic             QV
);

  localparam int unsigned      DEPTH      = 2 ** AW;
  localparam bit               WriteFirst = (WRITE_MODE == WM_WRITE_FIRST);
  localparam bit               RegSet     = (REGSET == "SET");
  localparam logic [WIDTH-1:0] RstVal     = WIDTH'(rst_word(RegSet, WIDTH));

  if (!aw_ok(AW)) begin : g_bad_aw
    $error("sdpram_dist_reg: AW must be 1..8");
  end
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("sdpram_dist_reg: WIDTH must be 1..64");
  end
  if (!stages_ok(REG_STAGES)) begin : g_bad_stages
    $error("sdpram_dist_reg: REG_STAGES must be 1 or 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WRE) begin
      mem[WAD] <= WD;
    end
  end

  assign F = mem[RAD];

  logic             collide;
  logic [WIDTH-1:0] rd_word;

  // The array holds the pre-write word at the edge, so READ_FIRST needs no bypass.
  assign collide = WRE && (WAD == RAD);
  assign rd_word = (WriteFirst && collide) ? WD : mem[RAD];

  logic [WIDTH-1:0]    sd [REG_STAGES+1];
  logic [REG_STAGES:0] sv;

  assign sd[0] = rd_word;
  assign sv[0] = RE;

  for (genvar i = 0; i < REG_STAGES; i++) begin : g_stage
    localparam bit First = (i == 0);
    rd_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RstVal)
    ) u_stage (
      .CLK (CLK),
      .LSR (LSR),
      .CE  (CE),
      .LD  (First ? RE : 1'b1),
      .VIN (sv[i]),
      .D   (sd[i]),
      .Q   (sd[i+1]),
      .QV  (sv[i+1])
    );
  end

  assign Q  = sd[REG_STAGES];
  assign QV = sv[REG_STAGES];

endmodule
